// File: rtl/sram_1rw_mask_ext_if.sv
// sram_1rw_mask_ext_if: request/response bus of the masked single-port SRAM.
// The master drives the request fields; the slave returns ready and read data.
interface sram_1rw_mask_ext_if #(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 8
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SEG = WIDTH / MASK_GRAN;

    logic [AW-1:0]    RW0_addr;
    logic             RW0_en;
    logic             RW0_wmode;
    logic [SEG-1:0]   RW0_wmask;
    logic [WIDTH-1:0] RW0_wdata;
    logic             RW0_pinj;
    logic             RW0_ready;
    logic [WIDTH-1:0] RW0_rdata;
    logic             RW0_rvalid;
    logic             RW0_perr;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, RW0_pinj,
        input  RW0_ready, RW0_rdata, RW0_rvalid, RW0_perr
    );
    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, RW0_pinj,
        output RW0_ready, RW0_rdata, RW0_rvalid, RW0_perr
    );
endinterface

// File: rtl/sram_1rw_mask_ext.sv
// sram_1rw_mask_ext: masked single-port SRAM, zeroed by a sweep after reset, READ_LAT 1 or 2.
// Define SRAM_PARITY_EN to store one even-parity bit per mask segment and flag mismatches.
module sram_1rw_mask_ext #(
    parameter int DEPTH     = 1024,
    parameter int WIDTH     = 64,
    parameter int MASK_GRAN = 8,
    parameter int READ_LAT  = 1
) (
    input logic                RW0_clk,
    input logic                RW0_reset,
    sram_1rw_mask_ext_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SEG = WIDTH / MASK_GRAN;
    localparam logic [AW:0]   DEP  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic             ready;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             in_range, rd, we, mism;
    logic [AW-1:0]    wa;
    logic [SEG-1:0]   wm;
    logic [WIDTH-1:0] wd, bm;
    logic             v1, p1;
    logic [WIDTH-1:0] d1;

    // The sweep owns the write port until every word is zeroed.
    always_comb begin
        in_range = {1'b0, bus.RW0_addr} < DEP;
        rd = ready & bus.RW0_en & ~bus.RW0_wmode;
        we = (state == CLEAR) | (ready & bus.RW0_en & bus.RW0_wmode & in_range);
        wa = (state == CLEAR) ? cnt : bus.RW0_addr;
        wm = (state == CLEAR) ? '1 : bus.RW0_wmask;
        wd = (state == CLEAR) ? '0 : bus.RW0_wdata;
        bm = '0;
        for (int s = 0; s < SEG; s++)
            bm[s*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wm[s]}};
    end

    always_ff @(posedge RW0_clk or posedge RW0_reset)
        if (RW0_reset) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state <= READY;
                ready <= 1'b1;
            end
        end

    always_ff @(posedge RW0_clk)
        if (we) mem[wa] <= (mem[wa] & ~bm) | (wd & bm);

`ifdef SRAM_PARITY_EN
    logic [SEG-1:0] par [DEPTH];
    logic [SEG-1:0] wpar, rpar;

    always_comb begin
        wpar = '0;
        rpar = '0;
        for (int s = 0; s < SEG; s++) begin
            wpar[s] = ^wd[s*MASK_GRAN +: MASK_GRAN] ^ (bus.RW0_pinj & (state == READY));
            rpar[s] = ^mem[bus.RW0_addr][s*MASK_GRAN +: MASK_GRAN];
        end
        mism = in_range & (rpar != par[bus.RW0_addr]);
    end

    always_ff @(posedge RW0_clk)
        if (we) par[wa] <= (par[wa] & ~wm) | (wpar & wm);
`else
    logic unused_pinj;
    assign unused_pinj = bus.RW0_pinj;
    assign mism = 1'b0;
`endif

    // Out-of-range reads still answer, with a zero word and no parity error.
    always_ff @(posedge RW0_clk or posedge RW0_reset)
        if (RW0_reset) begin
            v1 <= 1'b0;
            p1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd;
            p1 <= rd & mism;
            if (rd) d1 <= in_range ? mem[bus.RW0_addr] : '0;
        end

    generate
        if (READ_LAT == 1) begin : g_lat1
            assign bus.RW0_rvalid = v1;
            assign bus.RW0_perr   = p1;
            assign bus.RW0_rdata  = d1;
        end else begin : g_lat2
            logic             v2, p2;
            logic [WIDTH-1:0] d2;
            always_ff @(posedge RW0_clk or posedge RW0_reset)
                if (RW0_reset) begin
                    v2 <= 1'b0;
                    p2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    p2 <= p1;
                    if (v1) d2 <= d1;
                end
            assign bus.RW0_rvalid = v2;
            assign bus.RW0_perr   = p2;
            assign bus.RW0_rdata  = d2;
        end
    endgenerate

    assign bus.RW0_ready = ready;
endmodule

// File: tb/tb_sram_1rw_mask_ext.sv
// tb_sram_1rw_mask_ext: two instances (DEPTH 16 / READ_LAT 1 and DEPTH 1000 / READ_LAT 2)
// driven by directed steps; reads are scored against a shadow model queued at issue time.
module tb_sram_1rw_mask_ext;
    localparam int DA = 16;
    localparam int DB = 1000;
`ifdef SRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [63:0] d;
        logic        p;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$], q1[$];
    logic [63:0] mm [2][DB];
    logic [7:0]  pm [2][DB];
    bit          rdy [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_1rw_mask_ext_if #(.DEPTH(DA), .WIDTH(64), .MASK_GRAN(8)) a_if ();
    sram_1rw_mask_ext_if #(.DEPTH(DB), .WIDTH(64), .MASK_GRAN(8)) b_if ();

    sram_1rw_mask_ext #(.DEPTH(DA), .WIDTH(64), .MASK_GRAN(8), .READ_LAT(1)) dut_a (
        .RW0_clk(clk), .RW0_reset(rst), .bus(a_if)
    );
    sram_1rw_mask_ext #(.DEPTH(DB), .WIDTH(64), .MASK_GRAN(8), .READ_LAT(2)) dut_b (
        .RW0_clk(clk), .RW0_reset(rst), .bus(b_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one instance for the coming edge and updates the model / scoreboard.
    task automatic set(input int w, input bit en, input bit wmd, input int addr,
                       input logic [7:0] mask, input logic [63:0] data, input bit pinj);
        int   dep;
        int   ea;
        exp_t e;
        dep = w ? DB : DA;
        ea  = w ? (addr & 1023) : (addr & 15);
        if (w == 0) begin
            a_if.RW0_en = en; a_if.RW0_wmode = wmd; a_if.RW0_addr = 4'(ea);
            a_if.RW0_wmask = mask; a_if.RW0_wdata = data; a_if.RW0_pinj = pinj;
        end else begin
            b_if.RW0_en = en; b_if.RW0_wmode = wmd; b_if.RW0_addr = 10'(ea);
            b_if.RW0_wmask = mask; b_if.RW0_wdata = data; b_if.RW0_pinj = pinj;
        end
        if (en && rdy[w]) begin
            if (wmd) begin
                if (ea < dep)
                    for (int s = 0; s < 8; s++)
                        if (mask[s]) begin
                            mm[w][ea][s*8 +: 8] = data[s*8 +: 8];
                            pm[w][ea][s] = PAR & pinj;
                        end
            end else begin
                e.d = (ea < dep) ? mm[w][ea] : 64'd0;
                e.p = (ea < dep) ? |pm[w][ea] : 1'b0;
                e.due = cyc + (w ? 2 : 1);
                if (w == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    endtask

    task automatic idle();
        set(0, 0, 0, 0, 8'h00, 64'd0, 0);
        set(1, 0, 0, 0, 8'h00, 64'd0, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        q0.delete();
        q1.delete();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < DB; i++) begin
                mm[w][i] = 64'd0;
                pm[w][i] = 8'd0;
            end
    endtask

    task automatic chk_reset_vals();
        chk("a_reset_ready", a_if.RW0_ready, 0);
        chk("a_reset_rdata", a_if.RW0_rdata, 0);
        chk("a_reset_rvalid", a_if.RW0_rvalid, 0);
        chk("a_reset_perr", a_if.RW0_perr, 0);
        chk("b_reset_ready", b_if.RW0_ready, 0);
        chk("b_reset_rdata", b_if.RW0_rdata, 0);
        chk("b_reset_rvalid", b_if.RW0_rvalid, 0);
        chk("b_reset_perr", b_if.RW0_perr, 0);
    endtask

    // Counts cycles from reset release until each instance reports ready.
    task automatic wait_ready();
        int n, na, nb;
        n = 0; na = -1; nb = -1;
        while ((na < 0 || nb < 0) && n < 1200) begin
            @(negedge clk);
            n++;
            if (na < 0 && a_if.RW0_ready === 1'b1) begin na = n; set(0, 0, 0, 0, 8'h00, 64'd0, 0); end
            if (nb < 0 && b_if.RW0_ready === 1'b1) begin nb = n; set(1, 0, 0, 0, 8'h00, 64'd0, 0); end
        end
        chk("a_ready_latency", 64'(na), 64'(DA));
        chk("b_ready_latency", 64'(nb), 64'(DB));
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_if.RW0_rvalid) begin
            if (q0.size() == 0) chk("a_rvalid_unexpected", a_if.RW0_rvalid, 0);
            else begin
                e = q0.pop_front();
                chk("a_rdata", a_if.RW0_rdata, e.d);
                chk("a_perr", a_if.RW0_perr, e.p);
                chk("a_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
            chk("a_rvalid_missing", a_if.RW0_rvalid, 1);
            void'(q0.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_if.RW0_rvalid) begin
            if (q1.size() == 0) chk("b_rvalid_unexpected", b_if.RW0_rvalid, 0);
            else begin
                e = q1.pop_front();
                chk("b_rdata", b_if.RW0_rdata, e.d);
                chk("b_perr", b_if.RW0_perr, e.p);
                chk("b_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
            chk("b_rvalid_missing", b_if.RW0_rvalid, 1);
            void'(q1.pop_front());
        end
    end

    initial begin
        do_reset();
        idle();
        step(2);
        chk_reset_vals();
        // Requests held during the sweep must be ignored.
        set(0, 1, 1, 3, 8'hFF, 64'hDEAD_BEEF_0123_4567, 0);
        set(1, 1, 0, 5, 8'h00, 64'd0, 0);
        rst = 1'b0;
        wait_ready();
        for (int i = 0; i < DA; i++) begin
            set(0, 1, 0, i, 8'h00, 64'd0, 0);
            set(1, 1, 0, i * 61, 8'h00, 64'd0, 0);
            step(1);
        end
        idle();
        step(3);
        // Masked overwrite, then read-after-write on the next cycle.
        for (int w = 0; w < 2; w++) begin
            set(w, 1, 1, 5, 8'hFF, 64'h1122_3344_5566_7788, 0);
            step(1);
            set(w, 1, 1, 5, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 0);
            step(1);
            set(w, 1, 0, 5, 8'h00, 64'd0, 0);
            step(1);
            idle();
            step(4);
        end
        chk("a_rdata_hold", a_if.RW0_rdata, 64'h1122_3344_AAAA_AAAA);
        chk("b_rdata_hold", b_if.RW0_rdata, 64'h1122_3344_AAAA_AAAA);
        // Random mixed traffic, including out-of-range addresses on the 1000-word instance.
        for (int k = 0; k < 60; k++) begin
            for (int w = 0; w < 2; w++)
                set(w, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    w ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 15)),
                    8'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) == 0);
            step(1);
        end
        idle();
        step(3);
        // Out-of-range write dropped, no aliasing into valid words.
        set(1, 1, 1, 1010, 8'hFF, 64'hFEED_FACE_CAFE_BABE, 0);
        step(1);
        set(1, 1, 0, 1010, 8'h00, 64'd0, 0); step(1);
        set(1, 1, 0, 1002, 8'h00, 64'd0, 0); step(1);
        set(1, 1, 0, 10, 8'h00, 64'd0, 0);   step(1);
        set(1, 1, 0, 498, 8'h00, 64'd0, 0);  step(1);
        set(1, 1, 0, 999, 8'h00, 64'd0, 0);  step(1);
        idle();
        step(3);
        // Parity injection on segment 0, then a clean rewrite.
        set(0, 1, 1, 7, 8'h01, 64'h0000_0000_0000_005A, 1); step(1);
        set(0, 1, 0, 7, 8'h00, 64'd0, 0); step(1);
        set(0, 1, 1, 7, 8'h01, 64'h0000_0000_0000_005B, 0); step(1);
        set(0, 1, 0, 7, 8'h00, 64'd0, 0); step(1);
        idle();
        step(3);
        // Back-to-back pipelined reads on the two-cycle instance.
        for (int i = 1; i <= 3; i++) begin
            set(1, 1, 1, i, 8'hFF, 64'h0101_0101_0101_0101 * i, 0);
            step(1);
        end
        for (int i = 1; i <= 3; i++) begin
            set(1, 1, 0, i, 8'h00, 64'd0, 0);
            step(1);
        end
        idle();
        step(4);
        // Reset one cycle after a read: the two-cycle read must vanish.
        set(0, 1, 0, 5, 8'h00, 64'd0, 0);
        set(1, 1, 0, 2, 8'h00, 64'd0, 0);
        step(1);
        idle();
        #2;
        do_reset();
        #1;
        chk_reset_vals();
        step(2);
        rst = 1'b0;
        step(5);
        // Reset again mid-sweep: the sweep restarts from address 0.
        do_reset();
        step(1);
        rst = 1'b0;
        wait_ready();
        for (int i = 0; i < DA; i++) begin
            set(0, 1, 0, i, 8'h00, 64'd0, 0);
            set(1, 1, 0, i, 8'h00, 64'd0, 0);
            step(1);
        end
        idle();
        step(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
